// File: rtl/tree_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tree_channel_scheduler
//
// Shares one decision-tree classification engine among CHANNEL_COUNT electrode
// channels. Channels raise req when a spike feature vector is ready. Requests
// are granted round-robin, the engine is started on the granted channel, and
// the engine's done is awaited with a timeout. Every outcome (engine result or
// timeout) is presented as a tagged result on a valid/ready port toward the
// cluster-label FIFO. Only one transaction is in flight at a time.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   req              per-channel pending request, held until acked
//   ack              one-hot single-cycle pulse: request accepted
//   engine_ready     engine idle (looked at only while idle)
//   engine_start     single-cycle start pulse
//   engine_ch        channel index for the engine, stable until result leaves
//   engine_abort     single-cycle pulse when the engine timed out
//   engine_done      engine result strobe, with engine_level / engine_path
//   res_valid/ready  result handshake
//   res_ch           result channel tag
//   res_level        captured final tree depth (0 on timeout)
//   res_path         captured decision path (0 on timeout)
//   res_timeout      result came from a timeout
//   timeout_count    saturating count of timeouts
// -----------------------------------------------------------------------------
module tree_channel_scheduler #(
   parameter int CHANNEL_COUNT  = 16,
   parameter int LEVEL_WIDTH    = 2,
   parameter int PATH_WIDTH     = 3,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CH_W           = $clog2(CHANNEL_COUNT)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CHANNEL_COUNT-1:0] req,
   output logic [CHANNEL_COUNT-1:0] ack,
   input  logic                     engine_ready,
   output logic                     engine_start,
   output logic [CH_W-1:0]          engine_ch,
   output logic                     engine_abort,
   input  logic                     engine_done,
   input  logic [LEVEL_WIDTH-1:0]   engine_level,
   input  logic [PATH_WIDTH-1:0]    engine_path,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [CH_W-1:0]          res_ch,
   output logic [LEVEL_WIDTH-1:0]   res_level,
   output logic [PATH_WIDTH-1:0]    res_path,
   output logic                     res_timeout,
   output logic [7:0]               timeout_count
);

   // The wait counter reads k-1 in the k-th WAIT cycle. The timeout decision is
   // taken when it reads TIMEOUT_CYCLES-2, so the registered abort pulse lands
   // exactly TIMEOUT_CYCLES cycles after the start pulse. A done arriving in
   // that decision cycle still wins over the timeout.
   localparam int                CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
   localparam logic [CH_W:0]     CH_CNT   = (CH_W+1)'(CHANNEL_COUNT);
   localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNEL_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_EMIT  = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [CH_W-1:0]            ptr_q, ptr_d;
   logic [CNT_W-1:0]           wait_cnt_q, wait_cnt_d;
   logic [CHANNEL_COUNT-1:0]   ack_q, ack_d;
   logic                       engine_start_q, engine_start_d;
   logic [CH_W-1:0]            engine_ch_q, engine_ch_d;
   logic                       engine_abort_q, engine_abort_d;
   logic                       res_valid_q, res_valid_d;
   logic [CH_W-1:0]            res_ch_q, res_ch_d;
   logic [LEVEL_WIDTH-1:0]     res_level_q, res_level_d;
   logic [PATH_WIDTH-1:0]      res_path_q, res_path_d;
   logic                       res_timeout_q, res_timeout_d;
   logic [7:0]                 timeout_count_q, timeout_count_d;

   // Round-robin pick: first set request at or after ptr_q, wrapping.
   logic                       found;
   logic [CH_W-1:0]            pick;
   logic [CH_W:0]              idx_sum;
   logic [CHANNEL_COUNT-1:0]   pick_onehot;

   always_comb begin
      found   = 1'b0;
      pick    = '0;
      idx_sum = '0;
      // Scan from the farthest offset down so the nearest request wins last.
      for (int k = CHANNEL_COUNT - 1; k >= 0; k--) begin
         idx_sum = {1'b0, ptr_q} + (CH_W+1)'(k);
         if (idx_sum >= CH_CNT) begin
            idx_sum = idx_sum - CH_CNT;
         end
         if (req[idx_sum[CH_W-1:0]]) begin
            found = 1'b1;
            pick  = idx_sum[CH_W-1:0];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_onehot
         assign pick_onehot[gi] = (pick == CH_W'(gi));
      end
   endgenerate

   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      wait_cnt_d      = wait_cnt_q;
      ack_d           = '0;
      engine_start_d  = 1'b0;
      engine_abort_d  = 1'b0;
      engine_ch_d     = engine_ch_q;
      res_valid_d     = res_valid_q;
      res_ch_d        = res_ch_q;
      res_level_d     = res_level_q;
      res_path_d      = res_path_q;
      res_timeout_d   = res_timeout_q;
      timeout_count_d = timeout_count_q;

      case (state_q)
         ST_IDLE: begin
            if (found && engine_ready) begin
               // Pulses are registered here so they appear during ISSUE.
               engine_ch_d    = pick;
               ack_d          = pick_onehot;
               engine_start_d = 1'b1;
               ptr_d          = (pick == CH_LAST) ? '0 : pick + CH_W'(1);
               state_d        = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // engine_done is deliberately not looked at here.
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
         end

         ST_WAIT: begin
            if (engine_done) begin
               res_valid_d   = 1'b1;
               res_ch_d      = engine_ch_q;
               res_level_d   = engine_level;
               res_path_d    = engine_path;
               res_timeout_d = 1'b0;
               state_d       = ST_EMIT;
            end else if (wait_cnt_q == CNT_LAST) begin
               engine_abort_d = 1'b1;
               res_valid_d    = 1'b1;
               res_ch_d       = engine_ch_q;
               res_level_d    = '0;
               res_path_d     = '0;
               res_timeout_d  = 1'b1;
               if (timeout_count_q != 8'hFF) begin
                  timeout_count_d = timeout_count_q + 8'd1;
               end
               state_d = ST_EMIT;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end

         ST_EMIT: begin
            // Result fields hold until the downstream takes them.
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         ptr_q           <= '0;
         wait_cnt_q      <= '0;
         ack_q           <= '0;
         engine_start_q  <= 1'b0;
         engine_ch_q     <= '0;
         engine_abort_q  <= 1'b0;
         res_valid_q     <= 1'b0;
         res_ch_q        <= '0;
         res_level_q     <= '0;
         res_path_q      <= '0;
         res_timeout_q   <= 1'b0;
         timeout_count_q <= '0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         wait_cnt_q      <= wait_cnt_d;
         ack_q           <= ack_d;
         engine_start_q  <= engine_start_d;
         engine_ch_q     <= engine_ch_d;
         engine_abort_q  <= engine_abort_d;
         res_valid_q     <= res_valid_d;
         res_ch_q        <= res_ch_d;
         res_level_q     <= res_level_d;
         res_path_q      <= res_path_d;
         res_timeout_q   <= res_timeout_d;
         timeout_count_q <= timeout_count_d;
      end
   end

   assign ack           = ack_q;
   assign engine_start  = engine_start_q;
   assign engine_ch     = engine_ch_q;
   assign engine_abort  = engine_abort_q;
   assign res_valid     = res_valid_q;
   assign res_ch        = res_ch_q;
   assign res_level     = res_level_q;
   assign res_path      = res_path_q;
   assign res_timeout   = res_timeout_q;
   assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_tree_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tree_channel_scheduler
//
// Directed bench for tree_channel_scheduler (16 channels, timeout 64). Each
// scenario task drives its own stimulus and compares against hand-computed
// values. Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_tree_channel_scheduler;

   logic        clk;
   logic        reset;
   logic [15:0] req;
   logic [15:0] ack;
   logic        engine_ready;
   logic        engine_start;
   logic [3:0]  engine_ch;
   logic        engine_abort;
   logic        engine_done;
   logic [1:0]  engine_level;
   logic [2:0]  engine_path;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_ch;
   logic [1:0]  res_level;
   logic [2:0]  res_path;
   logic        res_timeout;
   logic [7:0]  timeout_count;

   int n_cmp = 0;
   int n_err = 0;

   // Observations of the last do_txn call.
   logic [15:0] obs_ack;
   logic [3:0]  obs_ch;
   logic [3:0]  obs_res_ch;
   logic [1:0]  obs_lv;
   logic [2:0]  obs_pa;
   logic        obs_to;
   logic        obs_ab;
   int          obs_lat;
   int          obs_ok;

   tree_channel_scheduler #(
      .CHANNEL_COUNT  (16),
      .LEVEL_WIDTH    (2),
      .PATH_WIDTH     (3),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .ack           (ack),
      .engine_ready  (engine_ready),
      .engine_start  (engine_start),
      .engine_ch     (engine_ch),
      .engine_abort  (engine_abort),
      .engine_done   (engine_done),
      .engine_level  (engine_level),
      .engine_path   (engine_path),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_ch        (res_ch),
      .res_level     (res_level),
      .res_path      (res_path),
      .res_timeout   (res_timeout),
      .timeout_count (timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset        = 1'b1;
      req          = '0;
      engine_ready = 1'b1;
      engine_done  = 1'b0;
      engine_level = '0;
      engine_path  = '0;
      res_ready    = 1'b1;
      tick;
      tick;
      reset = 1'b0;
   endtask

   task automatic wait_start(output int ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (engine_start) begin
            ok = 1;
            break;
         end
      end
   endtask

   // One complete transaction: waits for the start, drops the granted req bit,
   // returns done done_dly cycles after the start cycle, takes the result.
   task automatic do_txn(input int done_dly, input logic [1:0] lv, input logic [2:0] pa);
      int ok;
      obs_ab  = 1'b0;
      obs_lat = 0;
      obs_ok  = 0;
      wait_start(ok);
      if (ok == 0) return;
      obs_ack = ack;
      obs_ch  = engine_ch;
      req     = req & ~ack;
      for (int d = 0; d < done_dly; d++) begin
         tick;
         obs_lat++;
         obs_ab = obs_ab | engine_abort;
      end
      engine_done  = 1'b1;
      engine_level = lv;
      engine_path  = pa;
      tick;
      obs_lat++;
      obs_ab       = obs_ab | engine_abort;
      engine_done  = 1'b0;
      engine_level = '0;
      engine_path  = '0;
      for (int i = 0; i < 100 && !res_valid; i++) begin
         tick;
         obs_lat++;
         obs_ab = obs_ab | engine_abort;
      end
      if (!res_valid) return;
      obs_ok     = 1;
      obs_res_ch = res_ch;
      obs_lv     = res_level;
      obs_pa     = res_path;
      obs_to     = res_timeout;
      tick;
   endtask

   task automatic test_reset;
      reset        = 1'b1;
      req          = 16'hFFFF;
      engine_ready = 1'b1;
      engine_done  = 1'b1;
      engine_level = 2'd3;
      engine_path  = 3'd7;
      res_ready    = 1'b0;
      tick;
      tick;
      n_cmp++; if (ack !== 16'h0) begin n_err++; $display("FAIL reset_ack: got %h want 0000", ack); end
      n_cmp++; if (engine_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", engine_start); end
      n_cmp++; if (engine_abort !== 1'b0) begin n_err++; $display("FAIL reset_abort: got %b want 0", engine_abort); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      n_cmp++; if (engine_ch !== 4'd0) begin n_err++; $display("FAIL reset_engine_ch: got %0d want 0", engine_ch); end
      n_cmp++; if ({res_ch, res_level, res_path, res_timeout} !== 10'd0) begin
         n_err++; $display("FAIL reset_res_fields: got ch=%0d lv=%0d pa=%0d to=%b want all 0", res_ch, res_level, res_path, res_timeout);
      end
      n_cmp++; if (timeout_count !== 8'd0) begin n_err++; $display("FAIL reset_timeout_count: got %0d want 0", timeout_count); end
      reset        = 1'b0;
      req          = '0;
      engine_done  = 1'b0;
      engine_level = '0;
      engine_path  = '0;
      res_ready    = 1'b1;
      tick;
      n_cmp++; if ({ack, engine_start} !== 17'd0) begin n_err++; $display("FAIL reset_idle_quiet: got ack=%h start=%b want 0", ack, engine_start); end
      $display("test_reset: done");
   endtask

   task automatic test_single;
      do_reset;
      req = 16'h0020;
      do_txn(3, 2'd2, 3'b101);
      n_cmp++; if (obs_ok !== 1) begin n_err++; $display("FAIL single_complete: got %0d want 1", obs_ok); end
      n_cmp++; if (obs_ack !== 16'h0020) begin n_err++; $display("FAIL single_ack: got %h want 0020", obs_ack); end
      n_cmp++; if (obs_ch !== 4'd5) begin n_err++; $display("FAIL single_engine_ch: got %0d want 5", obs_ch); end
      n_cmp++; if (obs_lat !== 4) begin n_err++; $display("FAIL single_latency: got %0d want 4", obs_lat); end
      n_cmp++; if ({obs_res_ch, obs_lv, obs_pa, obs_to} !== {4'd5, 2'd2, 3'd5, 1'b0}) begin
         n_err++; $display("FAIL single_result: got ch=%0d lv=%0d pa=%0d to=%b want ch=5 lv=2 pa=5 to=0", obs_res_ch, obs_lv, obs_pa, obs_to);
      end
      n_cmp++; if ({timeout_count, res_valid} !== 9'd0) begin
         n_err++; $display("FAIL single_after: got tcount=%0d valid=%b want 0 0", timeout_count, res_valid);
      end
      $display("test_single: grant ch=%0d result ch=%0d lv=%0d pa=%0d", obs_ch, obs_res_ch, obs_lv, obs_pa);
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_ch [4];
      exp_ch[0] = 4'd0; exp_ch[1] = 4'd1; exp_ch[2] = 4'd15; exp_ch[3] = 4'd0;
      do_reset;
      req = 16'h8003;
      for (int t = 0; t < 4; t++) begin
         if (t == 3) req = 16'h0001;
         do_txn(1, 2'd1, 3'd1);
         n_cmp++; if (obs_ok !== 1 || obs_ch !== exp_ch[t]) begin
            n_err++; $display("FAIL rr_grant_%0d: got ch=%0d ok=%0d want ch=%0d ok=1", t, obs_ch, obs_ok, exp_ch[t]);
         end
         $display("test_round_robin: txn %0d granted ch=%0d", t, obs_ch);
      end
   endtask

   task automatic test_timeout;
      int ok;
      int n;
      int ab_cnt;
      do_reset;
      req = 16'h0001;
      wait_start(ok);
      req = 16'h0000;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         tick;
         n++;
         if (engine_abort) break;
      end
      n_cmp++; if (ok !== 1 || n !== 64) begin n_err++; $display("FAIL timeout_abort_delay: got %0d (start ok=%0d) want 64", n, ok); end
      n_cmp++; if ({res_valid, res_timeout, res_level, res_path, res_ch} !== {1'b1, 1'b1, 2'd0, 3'd0, 4'd0}) begin
         n_err++; $display("FAIL timeout_result: got v=%b to=%b lv=%0d pa=%0d ch=%0d want v=1 to=1 lv=0 pa=0 ch=0",
                           res_valid, res_timeout, res_level, res_path, res_ch);
      end
      n_cmp++; if (timeout_count !== 8'd1) begin n_err++; $display("FAIL timeout_count_one: got %0d want 1", timeout_count); end
      tick;
      n_cmp++; if ({engine_abort, res_valid} !== 2'b00) begin
         n_err++; $display("FAIL timeout_pulse_end: got abort=%b valid=%b want 0 0", engine_abort, res_valid);
      end
      $display("test_timeout: abort after %0d cycles, count=%0d", n, timeout_count);
      // Saturation: 299 more timeouts with the request held high.
      req    = 16'h0001;
      ab_cnt = 1;
      for (int c = 0; c < 30000 && ab_cnt < 300; c++) begin
         tick;
         if (engine_abort) ab_cnt++;
      end
      req = 16'h0000;
      n_cmp++; if (ab_cnt !== 300) begin n_err++; $display("FAIL timeout_300_reached: got %0d want 300", ab_cnt); end
      n_cmp++; if (timeout_count !== 8'd255) begin n_err++; $display("FAIL timeout_saturate: got %0d want 255", timeout_count); end
      $display("test_timeout: %0d timeouts, count=%0d", ab_cnt, timeout_count);
   endtask

   task automatic test_backpressure;
      int ok;
      logic stable;
      do_reset;
      req       = 16'hFFFF;
      res_ready = 1'b0;
      wait_start(ok);
      n_cmp++; if (ok !== 1 || engine_ch !== 4'd0) begin n_err++; $display("FAIL bp_first_grant: got ch=%0d ok=%0d want 0", engine_ch, ok); end
      tick;
      engine_done  = 1'b1;
      engine_level = 2'd3;
      engine_path  = 3'd6;
      tick;
      engine_done  = 1'b0;
      engine_level = '0;
      engine_path  = '0;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if ({res_valid, res_ch, res_level, res_path, res_timeout} !== {1'b1, 4'd0, 2'd3, 3'd6, 1'b0}
             || ack !== 16'h0 || engine_start !== 1'b0) stable = 1'b0;
         tick;
      end
      n_cmp++; if (stable !== 1'b1) begin
         n_err++; $display("FAIL bp_hold: got v=%b ch=%0d lv=%0d pa=%0d to=%b ack=%h start=%b want held result, no grant",
                           res_valid, res_ch, res_level, res_path, res_timeout, ack, engine_start);
      end
      res_ready = 1'b1;
      tick;
      n_cmp++; if ({res_valid, engine_start} !== 2'b00) begin
         n_err++; $display("FAIL bp_release: got valid=%b start=%b want 0 0", res_valid, engine_start);
      end
      tick;
      n_cmp++; if ({engine_start, engine_ch, ack} !== {1'b1, 4'd1, 16'h0002}) begin
         n_err++; $display("FAIL bp_next_grant: got start=%b ch=%0d ack=%h want 1 1 0002", engine_start, engine_ch, ack);
      end
      req = 16'h0000;
      $display("test_backpressure: next grant ch=%0d", engine_ch);
   endtask

   task automatic test_done_at_timeout;
      do_reset;
      req = 16'h0001;
      do_txn(63, 2'd1, 3'b011);
      n_cmp++; if (obs_ok !== 1 || obs_lat !== 64) begin
         n_err++; $display("FAIL edge_done_latency: got %0d ok=%0d want 64", obs_lat, obs_ok);
      end
      n_cmp++; if ({obs_to, obs_lv, obs_pa, obs_ab} !== {1'b0, 2'd1, 3'd3, 1'b0}) begin
         n_err++; $display("FAIL edge_done_wins: got to=%b lv=%0d pa=%0d abort=%b want to=0 lv=1 pa=3 abort=0", obs_to, obs_lv, obs_pa, obs_ab);
      end
      n_cmp++; if (timeout_count !== 8'd0) begin n_err++; $display("FAIL edge_done_count: got %0d want 0", timeout_count); end
      $display("test_done_at_timeout: to=%b lv=%0d pa=%0d", obs_to, obs_lv, obs_pa);
   endtask

   task automatic test_done_in_issue;
      int ok;
      logic early;
      do_reset;
      req = 16'h0001;
      wait_start(ok);
      req          = 16'h0000;
      engine_done  = 1'b1;
      engine_level = 2'd1;
      engine_path  = 3'd1;
      tick;
      engine_done  = 1'b0;
      engine_level = '0;
      engine_path  = '0;
      early = res_valid;
      tick;
      early = early | res_valid;
      n_cmp++; if (ok !== 1 || early !== 1'b0) begin n_err++; $display("FAIL issue_done_ignored: got valid=%b ok=%0d want 0", early, ok); end
      engine_done  = 1'b1;
      engine_level = 2'd2;
      engine_path  = 3'd2;
      tick;
      engine_done  = 1'b0;
      engine_level = '0;
      engine_path  = '0;
      n_cmp++; if ({res_valid, res_level, res_path, res_timeout} !== {1'b1, 2'd2, 3'd2, 1'b0}) begin
         n_err++; $display("FAIL issue_real_done: got v=%b lv=%0d pa=%0d to=%b want v=1 lv=2 pa=2 to=0", res_valid, res_level, res_path, res_timeout);
      end
      tick;
      $display("test_done_in_issue: result lv=%0d pa=%0d", res_level, res_path);
   endtask

   task automatic test_ready_gate;
      logic seen;
      do_reset;
      engine_ready = 1'b0;
      req          = 16'h0008;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         seen = seen | engine_start | (|ack);
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL ready_gate_hold: got grant=%b want 0", seen); end
      engine_ready = 1'b1;
      tick;
      n_cmp++; if ({engine_start, engine_ch, ack} !== {1'b1, 4'd3, 16'h0008}) begin
         n_err++; $display("FAIL ready_gate_grant: got start=%b ch=%0d ack=%h want 1 3 0008", engine_start, engine_ch, ack);
      end
      req = 16'h0000;
      $display("test_ready_gate: granted ch=%0d after ready", engine_ch);
   endtask

   task automatic test_reset_mid_wait;
      int ok;
      logic seen;
      do_reset;
      req = 16'h0010;
      wait_start(ok);
      req = 16'h0000;
      for (int i = 0; i < 5; i++) tick;
      reset = 1'b1;
      tick;
      n_cmp++; if (ok !== 1 || {ack, engine_start, engine_abort, res_valid, res_ch, res_level, res_path,
                                res_timeout, engine_ch, timeout_count} !== 41'd0) begin
         n_err++; $display("FAIL midreset_outputs: got ack=%h st=%b ab=%b v=%b ch=%0d ech=%0d tc=%0d ok=%0d want all 0",
                           ack, engine_start, engine_abort, res_valid, res_ch, engine_ch, timeout_count, ok);
      end
      reset       = 1'b0;
      engine_done = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick;
         engine_done = 1'b0;
         seen = seen | res_valid | engine_abort | engine_start;
      end
      n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_silent: got activity=%b want 0", seen); end
      // Pointer back at 0: channel 2 beats channel 5.
      req = 16'h0024;
      tick;
      n_cmp++; if ({engine_start, engine_ch, ack} !== {1'b1, 4'd2, 16'h0004}) begin
         n_err++; $display("FAIL midreset_ptr: got start=%b ch=%0d ack=%h want 1 2 0004", engine_start, engine_ch, ack);
      end
      req = 16'h0000;
      $display("test_reset_mid_wait: grant after reset ch=%0d", engine_ch);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_single;
      test_round_robin;
      test_timeout;
      test_backpressure;
      test_done_at_timeout;
      test_done_in_issue;
      test_ready_gate;
      test_reset_mid_wait;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
